gf32_reduce_acc: RTL and testbench

- Sequential stage directly downstream of the 32-bit overlap-free Karatsuba GF(2) multiplier; consumes its 63-bit carry-less product.
- Reduces the product modulo a fixed pentanomial P(x) = x^32 + POLY_LOW(x). Default P is x^32+x^7+x^3+x^2+1.
- Optionally XOR-accumulates reduced beats over a framed sequence and emits one 32-bit GF(2^32) result per frame.
- Two-stage pipeline with valid/ready handshake on both sides.

---
 rtl/gf32_pkg.sv | 26 ++
 rtl/gf32_fold.sv | 19 +
 rtl/gf32_reduce_acc.sv | 121 ++++++++++++
 tb/tb_gf32_reduce_acc.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf32_pkg.sv
// Shared constants and carry-less helpers for the GF(2^32)
// reduction/accumulation stage.
package gf32_pkg;

  localparam int RES_W  = 32;
  localparam int PROD_W = 63;
  localparam int HI_W   = PROD_W - RES_W;
  localparam int F1_W   = 38;

  localparam logic [RES_W-1:0] POLY_LOW_DEF = 32'h0000_008D;

  // Carry-less product of a (zero-extended) high part with POLY_LOW,
  // truncated to the fold width.
  function automatic logic [F1_W-1:0] clmul_fold(
    input logic [HI_W-1:0]  a,
    input logic [RES_W-1:0] poly
  );
    logic [F1_W-1:0] r;
    r = '0;
    for (int i = 0; i < RES_W; i++) begin
      if (poly[i]) r = r ^ (F1_W'(a) << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf32_fold.sv
// One combinational fold step: lo ^ clmul(hi, POLY_LOW),
// used for both the wide first fold and the narrow second fold.
import gf32_pkg::*;

module gf32_fold #(
  parameter int               IN_W  = 31,
  parameter int               OUT_W = 38,
  parameter logic [RES_W-1:0] POLY  = POLY_LOW_DEF
) (
  input  logic [IN_W-1:0]  hi,
  input  logic [RES_W-1:0] lo,
  output logic [OUT_W-1:0] f
);

  assign f = OUT_W'(
    {{(F1_W-RES_W){1'b0}}, lo} ^ clmul_fold(HI_W'(hi), POLY)
  );

endmodule

// File: rtl/gf32_reduce_acc.sv
// Two-stage GF(2^32) reduction of a 63-bit carry-less product,
// with optional per-frame XOR accumulation.
import gf32_pkg::*;

module gf32_reduce_acc #(
  parameter logic [RES_W-1:0] POLY_LOW = POLY_LOW_DEF,
  parameter int               ACC_MODE = 1,
  parameter int               CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_beats,
  output logic              frame_err
);

  logic             adv;
  logic [F1_W-1:0]  f1;
  logic [F1_W-1:0]  s1_f1;
  logic             s1_valid;
  logic             s1_first;
  logic             s1_last;
  logic [RES_W-1:0] r;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] acc_n;
  logic             frame_open;
  logic             start;
  logic             ferr_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  gf32_fold #(
    .IN_W (HI_W),
    .OUT_W(F1_W),
    .POLY (POLY_LOW)
  ) u_fold1 (
    .hi(in_prod[PROD_W-1:RES_W]),
    .lo(in_prod[RES_W-1:0]),
    .f (f1)
  );

  gf32_fold #(
    .IN_W (F1_W-RES_W),
    .OUT_W(RES_W),
    .POLY (POLY_LOW)
  ) u_fold2 (
    .hi(s1_f1[F1_W-1:RES_W]),
    .lo(s1_f1[RES_W-1:0]),
    .f (r)
  );

  // Frame bookkeeping: restart, running XOR, saturating count, errors
  always_comb begin
    start   = s1_first | !frame_open;
    acc_n   = (start ? '0 : acc) ^ r;
    count_n = start ? CNT_W'(1)
            : (&count ? count : count + CNT_W'(1));
    ferr_n  = (s1_first == frame_open);
  end

  // Stage 1: first fold result and framing flags
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_f1    <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_f1    <= f1;
      s1_first <= in_first;
      s1_last  <= in_last;
    end
  end

  // Stage 2: second fold, accumulate, and present result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_beats  <= '0;
      frame_err  <= 1'b0;
      acc        <= '0;
      frame_open <= 1'b0;
      count      <= '0;
    end else if (adv) begin
      out_valid <= 1'b0;
      if (s1_valid) begin
        if (ACC_MODE == 0) begin
          out_valid <= 1'b1;
          out_data  <= r;
          out_beats <= CNT_W'(1);
        end else begin
          count <= count_n;
          if (ferr_n) frame_err <= 1'b1;
          if (s1_last) begin
            out_valid  <= 1'b1;
            out_data   <= acc_n;
            out_beats  <= count_n;
            acc        <= '0;
            frame_open <= 1'b0;
          end else begin
            acc        <= acc_n;
            frame_open <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gf32_reduce_acc.sv
// Randomised bench for gf32_reduce_acc in both accumulate and
// per-beat modes against a polynomial long-division model.
module tb_gf32_reduce_acc;

  localparam logic [31:0] POLY = 32'h0000_008D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [62:0] a_in_prod = '0;
  logic        a_in_first = 1'b0;
  logic        a_in_last = 1'b0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [31:0] a_out_data;
  logic [7:0]  a_out_beats;
  logic        a_frame_err;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [62:0] b_in_prod = '0;
  logic        b_in_first = 1'b0;
  logic        b_in_last = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [31:0] b_out_data;
  logic [7:0]  b_out_beats;
  logic        b_frame_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [39:0] a_got[$];
  logic [39:0] a_exp[$];
  logic [39:0] b_got[$];
  logic [39:0] b_exp[$];

  bit          m_open;
  bit          m_err;
  logic [31:0] m_acc;
  int          m_cnt;

  always #5 clk = ~clk;

  gf32_reduce_acc #(
    .POLY_LOW(POLY), .ACC_MODE(1), .CNT_W(8)
  ) u_acc (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_prod(a_in_prod),
    .in_first(a_in_first), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_beats(a_out_beats),
    .frame_err(a_frame_err)
  );

  gf32_reduce_acc #(
    .POLY_LOW(POLY), .ACC_MODE(0), .CNT_W(8)
  ) u_beat (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_prod(b_in_prod),
    .in_first(b_in_first), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_beats(b_out_beats),
    .frame_err(b_frame_err)
  );

  // Record every completed output transfer
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (a_out_valid && a_out_ready)
        a_got.push_back({a_out_data, a_out_beats});
      if (b_out_valid && b_out_ready)
        b_got.push_back({b_out_data, b_out_beats});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // True remainder of p(x) mod x^32 + POLY(x) by long division
  function automatic logic [31:0] reduce(input logic [62:0] p);
    logic [62:0] t;
    logic [62:0] pp;
    t  = p;
    pp = (63'd1 << 32) | 63'(POLY);
    for (int i = 62; i >= 32; i--)
      if (t[i]) t = t ^ (pp << (i - 32));
    return t[31:0];
  endfunction

  function automatic logic [62:0] rnd63();
    return 63'({$urandom(), $urandom()});
  endfunction

  task automatic model_a(input logic [62:0] p,
                         input logic f, input logic l);
    if (f || !m_open) begin
      if (!f || m_open) m_err = 1'b1;
      m_acc = '0;
      m_cnt = 0;
    end
    m_acc = m_acc ^ reduce(p);
    if (m_cnt < 255) m_cnt++;
    if (l) begin
      a_exp.push_back({m_acc, 8'(m_cnt)});
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic send_a(input logic [62:0] p,
                        input logic f, input logic l);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_prod  = p;
    a_in_first = f;
    a_in_last  = l;
    #1;
    while (!a_in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_a ready=%b required 1", a_in_ready);
    end else begin
      model_a(p, f, l);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [62:0] p);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_prod  = p;
    b_in_first = 1'($urandom());
    b_in_last  = 1'($urandom());
    #1;
    while (!b_in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_b ready=%b required 1", b_in_ready);
    end else begin
      b_exp.push_back({reduce(p), 8'd1});
    end
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((a_got.size() < a_exp.size() ||
            b_got.size() < b_exp.size()) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_open = 1'b0;
    m_err  = 1'b0;
    m_acc  = '0;
    m_cnt  = 0;
    a_got.delete();
    a_exp.delete();
    b_got.delete();
    b_exp.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    n_vec += 6;
    if (a_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_a_valid got=%b want=0", a_out_valid);
    end
    if (a_out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_a_data got=%h want=0", a_out_data);
    end
    if (a_out_beats !== 8'h0) begin
      n_bad++;
      $display("FAIL rst_a_beats got=%h want=0", a_out_beats);
    end
    if (a_frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_a_ferr got=%b want=0", a_frame_err);
    end
    if (b_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_b_valid got=%b want=0", b_out_valid);
    end
    if (a_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_a_ready got=%b want=1", a_in_ready);
    end
  endtask

  task automatic test_reduce_x32();
    b_out_ready = 1'b1;
    send_b(63'd1 << 32);
    n_vec++;
    if (b_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_early got=%b want=0", b_out_valid);
    end
    @(negedge clk);
    n_vec += 3;
    if (b_out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_2cyc got=%b want=1", b_out_valid);
    end
    if (b_out_data !== 32'h0000_008D) begin
      n_bad++;
      $display("FAIL x32 got=%h want=0000008d", b_out_data);
    end
    if (b_out_beats !== 8'd1) begin
      n_bad++;
      $display("FAIL x32_beats got=%0d want=1", b_out_beats);
    end
    drain();
    b_got.delete();
    b_exp.delete();
  endtask

  task automatic test_back_to_back();
    time t0;
    send_b(63'd1 << 62);
    send_b(63'h1234_5678);
    drain();
    n_vec += 2;
    if (b_got.size() < 2 || b_got[0] !== {32'h4000_1037, 8'd1}) begin
      n_bad++;
      $display("FAIL x62 got=%h want=4000103701",
               b_got.size() > 0 ? b_got[0] : 40'h0);
    end
    if (b_got.size() < 2 || b_got[1] !== {32'h1234_5678, 8'd1}) begin
      n_bad++;
      $display("FAIL low_only got=%h want=1234567801",
               b_got.size() > 1 ? b_got[1] : 40'h0);
    end
    b_got.delete();
    b_exp.delete();
    t0 = $time;
    for (int i = 0; i < 30; i++) send_b(rnd63());
    n_vec++;
    if ($time - t0 != 300) begin
      n_bad++;
      $display("FAIL throughput got=%0t want=300", $time - t0);
    end
    drain();
    n_vec++;
    if (b_got.size() !== b_exp.size()) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d want=%0d",
               b_got.size(), b_exp.size());
    end
    foreach (b_exp[i]) if (i < b_got.size()) begin
      n_vec++;
      if (b_got[i] !== b_exp[i]) begin
        n_bad++;
        $display("FAIL b2b[%0d] got=%h want=%h",
                 i, b_got[i], b_exp[i]);
      end
    end
    b_got.delete();
    b_exp.delete();
  endtask

  task automatic test_acc_frame();
    int len;
    a_out_ready = 1'b1;
    send_a(63'd1 << 32, 1'b1, 1'b0);
    send_a(63'h8D, 1'b0, 1'b1);
    send_a(63'd1 << 62, 1'b1, 1'b1);
    for (int f = 0; f < 20; f++) begin
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++)
        send_a(rnd63(), k == 0, k == len - 1);
    end
    for (int k = 0; k < 300; k++)
      send_a(rnd63(), k == 0, k == 299);
    drain();
    n_vec += 4;
    if (a_got.size() < 2 || a_got[0] !== {32'h0, 8'd2}) begin
      n_bad++;
      $display("FAIL cancel got=%h want=0000000002",
               a_got.size() > 0 ? a_got[0] : 40'h0);
    end
    if (a_got.size() < 2 || a_got[1] !== {32'h4000_1037, 8'd1}) begin
      n_bad++;
      $display("FAIL one_beat got=%h want=4000103701",
               a_got.size() > 1 ? a_got[1] : 40'h0);
    end
    if (a_out_beats !== 8'hFF) begin
      n_bad++;
      $display("FAIL sat_beats got=%0d want=255", a_out_beats);
    end
    if (a_frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_ferr got=%b want=0", a_frame_err);
    end
    n_vec++;
    if (a_got.size() !== a_exp.size()) begin
      n_bad++;
      $display("FAIL acc_count got=%0d want=%0d",
               a_got.size(), a_exp.size());
    end
    foreach (a_exp[i]) if (i < a_got.size()) begin
      n_vec++;
      if (a_got[i] !== a_exp[i]) begin
        n_bad++;
        $display("FAIL acc[%0d] got=%h want=%h",
                 i, a_got[i], a_exp[i]);
      end
    end
    a_got.delete();
    a_exp.delete();
  endtask

  task automatic test_backpressure();
    logic [62:0] p0, p1, p2;
    p0 = rnd63();
    p1 = rnd63();
    p2 = rnd63();
    a_out_ready = 1'b0;
    fork
      begin
        send_a(p0, 1'b1, 1'b1);
        send_a(p1, 1'b1, 1'b1);
        send_a(p2, 1'b1, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        n_vec++;
        if (a_in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_ready got=%b want=0", a_in_ready);
        end
        repeat (2) @(negedge clk);
        a_out_ready = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (a_got.size() !== 3) begin
      n_bad++;
      $display("FAIL bp_count got=%0d want=3", a_got.size());
    end
    foreach (a_exp[i]) if (i < a_got.size()) begin
      n_vec++;
      if (a_got[i] !== a_exp[i]) begin
        n_bad++;
        $display("FAIL bp[%0d] got=%h want=%h",
                 i, a_got[i], a_exp[i]);
      end
    end
    a_got.delete();
    a_exp.delete();
  endtask

  task automatic test_frame_err();
    do_reset();
    send_a(rnd63(), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (a_frame_err !== 1'b1) begin
      n_bad++;
      $display("FAIL ferr_idle got=%b want=1", a_frame_err);
    end
    send_a(rnd63(), 1'b0, 1'b1);
    drain();
    n_vec++;
    if (a_got.size() !== 1 || a_got[0] !== a_exp[0]) begin
      n_bad++;
      $display("FAIL ferr_idle_res got=%h want=%h",
               a_got.size() > 0 ? a_got[0] : 40'h0, a_exp[0]);
    end
    do_reset();
    n_vec++;
    if (a_frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ferr_clr got=%b want=0", a_frame_err);
    end
    send_a(rnd63(), 1'b1, 1'b0);
    send_a(rnd63(), 1'b1, 1'b0);
    send_a(rnd63(), 1'b0, 1'b1);
    send_a(rnd63(), 1'b1, 1'b1);
    drain();
    n_vec += 3;
    if (a_got.size() !== 2 || a_got[0] !== a_exp[0]) begin
      n_bad++;
      $display("FAIL restart got=%h want=%h",
               a_got.size() > 0 ? a_got[0] : 40'h0, a_exp[0]);
    end
    if (a_got.size() !== 2 || a_got[1] !== a_exp[1]) begin
      n_bad++;
      $display("FAIL after_restart got=%h want=%h",
               a_got.size() > 1 ? a_got[1] : 40'h0, a_exp[1]);
    end
    if (a_frame_err !== 1'(m_err)) begin
      n_bad++;
      $display("FAIL ferr_sticky got=%b want=%b",
               a_frame_err, m_err);
    end
    a_got.delete();
    a_exp.delete();
  endtask

  task automatic test_reset_mid();
    send_a(rnd63(), 1'b1, 1'b0);
    send_a(rnd63(), 1'b0, 1'b0);
    do_reset();
    n_vec += 4;
    if (a_out_valid !== 1'b0 || a_out_beats !== 8'h0) begin
      n_bad++;
      $display("FAIL mid_rst_ctl got=%b/%0d want=0/0",
               a_out_valid, a_out_beats);
    end
    if (a_out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_rst_data got=%h want=0", a_out_data);
    end
    if (a_frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_ferr got=%b want=0", a_frame_err);
    end
    if (b_out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_rst_b got=%h want=0", b_out_data);
    end
    send_a(rnd63(), 1'b1, 1'b0);
    send_a(rnd63(), 1'b0, 1'b0);
    send_a(rnd63(), 1'b0, 1'b1);
    drain();
    n_vec += 2;
    if (a_got.size() !== 1 || a_got[0] !== a_exp[0]) begin
      n_bad++;
      $display("FAIL post_rst got=%h want=%h",
               a_got.size() > 0 ? a_got[0] : 40'h0, a_exp[0]);
    end
    if (a_frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst_ferr got=%b want=0", a_frame_err);
    end
    a_got.delete();
    a_exp.delete();
  endtask

  initial begin
    test_reset();
    test_reduce_x32();
    test_back_to_back();
    test_acc_frame();
    test_backpressure();
    test_frame_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
